// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: divisor write port, channel enables and divided outputs for clk_div_multi
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32
);
  localparam int SEL_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic              div_we;
  logic [SEL_W-1:0]  div_sel;
  logic [CNT_W-1:0]  div_half;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  modport master (output div_we, div_sel, div_half, ch_en, input clk_out, tick);
  modport slave (input div_we, div_sel, div_half, ch_en, output clk_out, tick);
endinterface

// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel 50% square-wave divider with shadowed divisors; tick pulses only when CLK_DIV_MULTI_TICK_EN is defined
module clk_div_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W = 32,
  parameter int DEFAULT_HALF = 1250000
) (
  input logic clk_in,
  input logic reset,
  clk_div_multi_if.slave bus
);
  localparam int SEL_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
  logic [CNT_W-1:0]  half_in;
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] tick_q;
  assign half_in = bus.div_half == '0 ? CNT_W'(1) : bus.div_half;
  assign bus.clk_out = clk_q;
  assign bus.tick = tick_q;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic             we;
    logic             bnd;
    logic             clk_r;
    // out-of-range selects match no channel, so they are dropped here
    assign we = bus.div_we && bus.div_sel == SEL_W'(i);
    assign bnd = bus.ch_en[i] && cnt == active - CNT_W'(1);
    always_ff @(posedge clk_in) begin
      if (reset) begin
        cnt <= '0;
        clk_r <= 1'b0;
        active <= RST_HALF;
        shadow <= RST_HALF;
      end else begin
        if (we) shadow <= half_in;
        if (!bus.ch_en[i]) begin
          cnt <= '0;
          clk_r <= 1'b0;
          active <= shadow;
        end else if (bnd) begin
          cnt <= '0;
          clk_r <= ~clk_r;
          active <= we ? half_in : shadow;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
    assign clk_q[i] = clk_r;
`ifdef CLK_DIV_MULTI_TICK_EN
    logic tick_r;
    always_ff @(posedge clk_in) tick_r <= !reset && bnd && !clk_r;
    assign tick_q[i] = tick_r;
`endif
  end
`ifndef CLK_DIV_MULTI_TICK_EN
  assign tick_q = '0;
`endif
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed checks of clk_div_multi waveforms against hand-derived patterns
module tb_clk_div_multi;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [4:0] clk_h [64];
  logic [4:0] tick_h [64];
  clk_div_multi_if #(.NUM_CH(5), .CNT_W(16)) bus ();
  clk_div_multi #(.NUM_CH(5), .CNT_W(16), .DEFAULT_HALF(5)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      clk_h[k] = bus.clk_out;
      tick_h[k] = bus.tick;
    end
  endtask
  task automatic wr(input logic [2:0] sel, input logic [15:0] val);
    bus.div_we = 1'b1;
    bus.div_sel = sel;
    bus.div_half = val;
    step();
    bus.div_we = 1'b0;
    step();
  endtask
  function automatic logic [63:0] col(input int ch, input int n, input bit use_tick);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r = {r[62:0], use_tick ? tick_h[k][ch] : clk_h[k][ch]};
    return r;
  endfunction
  function automatic logic [63:0] tk(input logic [63:0] v);
`ifdef CLK_DIV_MULTI_TICK_EN
    return v;
`else
    return v & 64'h0;
`endif
  endfunction
  initial begin
    logic [63:0] acc;
    bus.div_we = 1'b0;
    bus.div_sel = '0;
    bus.div_half = '0;
    bus.ch_en = '0;
    repeat (3) step();
    chk("rst_clk", 64'(bus.clk_out), 64'h0);
    chk("rst_tick", 64'(bus.tick), 64'h0);
    reset = 1'b0;
    step();
    bus.ch_en = 5'b00001;
    capture(20);
    chk("t1_clk", col(0, 20, 0), 64'h0F83E);
    chk("t1_tick", col(0, 20, 1), tk(64'h08020));
    acc = '0;
    for (int k = 0; k < 20; k++) acc = acc | 64'(clk_h[k][4:1]) | 64'(tick_h[k][4:1]);
    chk("t1_others", acc, 64'h0);
    repeat (5) step();
    chk("dis_high", 64'(bus.clk_out[0]), 64'h1);
    bus.ch_en = 5'b00000;
    step();
    chk("dis_low", 64'(bus.clk_out[0]), 64'h0);
    chk("dis_tick", 64'(bus.tick[0]), 64'h0);
    step();
    bus.ch_en = 5'b00001;
    capture(6);
    chk("reen_clk", col(0, 6, 0), 64'h03);
    chk("reen_tick", col(0, 6, 1), tk(64'h02));
    bus.ch_en = 5'b00000;
    wr(3'd1, 16'd4);
    bus.ch_en = 5'b00010;
    capture(5);
    chk("t2_clk_a", col(1, 5, 0), 64'h03);
    chk("t2_tick_a", col(1, 5, 1), tk(64'h02));
    bus.div_we = 1'b1;
    bus.div_sel = 3'd1;
    bus.div_half = 16'd2;
    step();
    bus.div_we = 1'b0;
    chk("t2_mid", 64'(bus.clk_out[1]), 64'h1);
    capture(8);
    chk("t2_clk_b", col(1, 8, 0), 64'h99);
    chk("t2_tick_b", col(1, 8, 1), tk(64'h11));
    bus.ch_en = 5'b00000;
    wr(3'd2, 16'd0);
    bus.ch_en = 5'b00100;
    capture(6);
    chk("t3_clk", col(2, 6, 0), 64'h2A);
    chk("t3_tick", col(2, 6, 1), tk(64'h2A));
    bus.ch_en = 5'b00000;
    wr(3'd3, 16'd3);
    bus.ch_en = 5'b01000;
    capture(5);
    chk("t4_clk_a", col(3, 5, 0), 64'h07);
    bus.div_we = 1'b1;
    bus.div_sel = 3'd3;
    bus.div_half = 16'd6;
    step();
    bus.div_we = 1'b0;
    chk("t4_bnd", 64'(bus.clk_out[3]), 64'h0);
    capture(12);
    chk("t4_clk_b", col(3, 12, 0), 64'h07E);
    chk("t4_tick_b", col(3, 12, 1), tk(64'h040));
    bus.ch_en = 5'b00000;
    wr(3'd5, 16'd1);
    wr(3'd6, 16'd1);
    wr(3'd7, 16'd1);
    bus.ch_en = 5'b10010;
    capture(5);
    chk("sel_ch4", col(4, 5, 0), 64'h01);
    chk("sel_ch1", col(1, 5, 0), 64'h0C);
    reset = 1'b1;
    bus.div_we = 1'b1;
    bus.div_sel = 3'd1;
    bus.div_half = 16'd2;
    step();
    chk("mid_rst_clk", 64'(bus.clk_out), 64'h0);
    chk("mid_rst_tick", 64'(bus.tick), 64'h0);
    reset = 1'b0;
    bus.div_we = 1'b0;
    capture(5);
    chk("post_rst_ch1", col(1, 5, 0), 64'h01);
    chk("post_rst_ch4", col(4, 5, 0), 64'h01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
